codec_i2s_port: RTL
===================

// Module: codec_i2s_port
// PURPOSE
//  I2S master audio port that sits directly downstream of codec_init. Once the
//  I2C configuration is done (init_done), it generates BCLK and LRCLK for the
//  codec and serialises stereo DAC samples onto DACDAT. It also deserialises
//  ADCDAT into stereo receive samples. It is the sample interface for all
//  downstream DSP blocks.
// PARAMETERS
//  BCLK_DIV  4   clk cycles per BCLK half-period; must be >=2
//                (25 MHz clk -> 3.125 MHz BCLK)
//  SLOT_W    32  BCLK periods per channel slot; frame = 2*SLOT_W BCLKs
//                (48.8 kHz at defaults)
//  DATA_W    24  sample width; must be <= SLOT_W-1
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-low reset
//  init_done  in   1       codec configured; level-sensitive run enable
//  tx_left    in   DATA_W  left DAC sample, two's complement
//  tx_right   in   DATA_W  right DAC sample
//  tx_valid   in   1       tx sample pair offered
//  tx_ready   out  1       holding register empty; pair accepted when valid&&ready
//  tx_underrun out 1       1-clk pulse: frame started with no pair held
//  rx_left    out  DATA_W  last received left ADC sample
//  rx_right   out  DATA_W  last received right ADC sample
//  rx_valid   out  1       1-clk pulse: rx_left/rx_right updated
//  bclk       out  1       I2S bit clock to codec
//  lrclk      out  1       I2S word select; 0 = left, 1 = right
//  dacdat     out  1       serial DAC data
//  adcdat     in   1       serial ADC data (already synchronised by the top level)
// BEHAVIOUR
//  Reset (reset==0 at a clk edge):
//   - bclk=0, lrclk=0, dacdat=0, tx_ready=1, tx_underrun=0, rx_valid=0,
//     rx_left=0, rx_right=0.
//   - Holding register empty. State IDLE. All counters 0.
//   - Reset asserted mid-frame aborts the frame immediately; no rx_valid is produced.
//  FSM:
//   - IDLE: bclk/lrclk/dacdat held at 0. Go to RUN on the first clk with init_done=1.
//   - RUN: div_cnt counts 0..BCLK_DIV-1. bclk toggles when div_cnt wraps.
//     bit index k (0..2*SLOT_W-1) advances on each bclk falling edge and wraps to 0.
//   - init_done dropping in RUN: finish the current frame, then return to IDLE at
//     the falling edge where k would wrap to 0. bclk ends low.
//   - First frame after IDLE starts with the first bclk falling edge at
//     BCLK_DIV clks after entry. That edge has k=0.
//  Frame timing (at falling edge k; p = k mod SLOT_W):
//   - lrclk = (k >= SLOT_W).
//   - dacdat = sample bit DATA_W-p for 1<=p<=DATA_W (MSB one BCLK after the
//     lrclk change, standard I2S). dacdat = 0 otherwise.
//   - adcdat is sampled on the bclk rising edge following falling edge k, for
//     1<=p<=DATA_W, MSB first.
//  TX path:
//   - At falling edge k=0, the holding register loads into the L/R shift registers
//     and is marked empty.
//   - If the holding register was empty at that edge: shift zeros and pulse
//     tx_underrun for 1 clk.
//   - tx_ready = holding register empty (registered).
//   - Accept in the same clk as a k=0 load: the load sees the old contents, and
//     the new pair lands in the holding register (tx_ready=0 next clk).
//   - tx_valid while tx_ready=0 is ignored; the source must hold its data.
//  RX path:
//   - One clk after the rising edge that captures the right-channel LSB
//     (k = SLOT_W+DATA_W): rx_left and rx_right update together and rx_valid
//     pulses for 1 clk.
//   - rx_left/rx_right hold their values until the next frame's update.
//   - No backpressure: the consumer must take the sample within one frame.
//  Latency: a pair accepted before k=0 has its left MSB on dacdat at k=1, i.e.
//   2*BCLK_DIV clks after the k=0 edge.
// TESTING
//  1. reset=0 for 3 clks, init_done=0 -> bclk=lrclk=dacdat=0, tx_ready=1,
//     no rx_valid for 1000 clks.
//  2. init_done=1, defaults -> bclk period 8 clks. lrclk period 512 clks with
//     50% duty. lrclk changes only on bclk falling edges.
//  3. Preload L=24'h800001, R=24'h7FFFFE -> dacdat serialises 1,0..0,1 in
//     left slot bits 1..24 and 0,1..1,0 in right slot bits 1..24; 0 elsewhere.
//  4. adcdat loopback from dacdat with L=24'hA5A5A5, R=24'h5A5A5A ->
//     next-frame rx_left=A5A5A5, rx_right=5A5A5A, exactly one rx_valid per frame.
//  5. No tx_valid for one frame -> tx_underrun pulses once at k=0 and dacdat=0
//     for the whole frame. Then tx_valid in the exact k=0 clk -> underrun
//     and pair transmitted next frame.
//  6. reset=0 at k=40, and separately init_done=0 at k=10 -> immediate idle
//     outputs vs. the frame completing to k=63, then IDLE with bclk=0.

Source files
------------

// File: rtl/codec_i2s_port_if.sv
// Bundle of the sample stream and I2S pin signals for the codec port.
// master: the port itself (drives the codec pins and the sample outputs).
// slave : the surrounding logic (offers DAC samples, consumes ADC samples).
interface codec_i2s_port_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] tx_left;
    logic [DATA_W-1:0] tx_right;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_underrun;
    logic [DATA_W-1:0] rx_left;
    logic [DATA_W-1:0] rx_right;
    logic              rx_valid;
    logic              bclk;
    logic              lrclk;
    logic              dacdat;
    logic              adcdat;

    modport master (
        input  tx_left, tx_right, tx_valid, adcdat,
        output tx_ready, tx_underrun, rx_left, rx_right, rx_valid,
        output bclk, lrclk, dacdat
    );

    modport slave (
        output tx_left, tx_right, tx_valid, adcdat,
        input  tx_ready, tx_underrun, rx_left, rx_right, rx_valid,
        input  bclk, lrclk, dacdat
    );
endinterface

// File: rtl/codec_i2s_port.sv
// I2S master audio port. Once the codec is configured it generates BCLK and
// LRCLK, serialises stereo DAC samples onto DACDAT (MSB one BCLK after the
// LRCLK change) and deserialises ADCDAT into stereo receive samples.
// Entering RUN raises bclk so that the first falling edge (bit index 0)
// lands BCLK_DIV clocks after entry.
module codec_i2s_port #(
    parameter int BCLK_DIV = 4,
    parameter int SLOT_W   = 32,
    parameter int DATA_W   = 24
) (
    input  logic clk,
    input  logic reset,
    input  logic init_done,
    codec_i2s_port_if.master i2s
);
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int DIV_W   = $clog2(BCLK_DIV);
    localparam int K_W     = $clog2(FRAME_W);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                   state;
    logic [DIV_W-1:0]         div_cnt;
    logic [K_W-1:0]           k_q;        // index of the next bclk falling edge
    logic                     bclk_q;
    logic                     lrclk_q;
    logic                     dacdat_q;
    logic                     underrun_q;
    logic                     tx_ready_q; // holding register empty
    logic signed [DATA_W-1:0] hold_l;
    logic signed [DATA_W-1:0] hold_r;
    logic signed [DATA_W-1:0] tx_sh_l;
    logic signed [DATA_W-1:0] tx_sh_r;
    logic signed [DATA_W-1:0] rx_sh_l;
    logic signed [DATA_W-1:0] rx_sh_r;
    logic signed [DATA_W-1:0] rx_left_q;
    logic signed [DATA_W-1:0] rx_right_q;
    logic                     rx_vld_p0;
    logic                     rx_vld_p1;

    logic                     div_wrap;
    logic                     fall_evt;
    logic                     rise_evt;
    logic                     fall_right;
    logic                     fall_bit;
    logic                     rise_right;
    logic                     rise_bit;
    logic                     rx_last;
    logic                     load_evt;
    logic                     stop_evt;
    logic                     accept;
    logic [K_W-1:0]           k_prev;
    logic [K_W-1:0]           p_fall;
    logic [K_W-1:0]           p_rise;

    // Decode bclk edges, slot positions and handshake events for this clk.
    always_comb begin
        div_wrap   = (div_cnt == DIV_W'(BCLK_DIV - 1));
        fall_evt   = (state == RUN) && div_wrap && bclk_q;
        rise_evt   = (state == RUN) && div_wrap && !bclk_q;
        fall_right = (k_q >= K_W'(SLOT_W));
        p_fall     = fall_right ? (k_q - K_W'(SLOT_W)) : k_q;
        fall_bit   = (p_fall >= K_W'(1)) && (p_fall <= K_W'(DATA_W));
        k_prev     = (k_q == '0) ? K_W'(FRAME_W - 1) : (k_q - K_W'(1));
        rise_right = (k_prev >= K_W'(SLOT_W));
        p_rise     = rise_right ? (k_prev - K_W'(SLOT_W)) : k_prev;
        rise_bit   = (p_rise >= K_W'(1)) && (p_rise <= K_W'(DATA_W));
        rx_last    = (k_prev == K_W'(SLOT_W + DATA_W));
        stop_evt   = fall_evt && (k_q == '0) && !init_done;
        load_evt   = fall_evt && (k_q == '0) && init_done;
        accept     = i2s.tx_valid && tx_ready_q;
    end

    // Run/idle FSM with bit-clock divider, frame bit counter and pin outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            k_q        <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            dacdat_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt  <= '0;
                    k_q      <= '0;
                    bclk_q   <= 1'b0;
                    lrclk_q  <= 1'b0;
                    dacdat_q <= 1'b0;
                    if (init_done) begin
                        state  <= RUN;
                        bclk_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (div_wrap) begin
                        div_cnt <= '0;
                        bclk_q  <= ~bclk_q;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                    if (stop_evt) begin
                        state    <= IDLE;
                        k_q      <= '0;
                        lrclk_q  <= 1'b0;
                        dacdat_q <= 1'b0;
                    end else if (fall_evt) begin
                        lrclk_q  <= fall_right;
                        dacdat_q <= fall_bit &&
                                    (fall_right ? tx_sh_r[DATA_W-1] : tx_sh_l[DATA_W-1]);
                        k_q      <= (k_q == K_W'(FRAME_W - 1)) ? '0 : (k_q + K_W'(1));
                        if ((k_q == '0) && tx_ready_q) begin
                            underrun_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Holding register status: filled by a handshake, emptied by the frame-start load.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tx_ready_q <= 1'b1;
        end else if (accept) begin
            tx_ready_q <= 1'b0;
        end else if (load_evt) begin
            tx_ready_q <= 1'b1;
        end
    end

    // Capture an accepted sample pair into the holding register.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_l <= i2s.tx_left;
            hold_r <= i2s.tx_right;
        end
    end

    // TX shifters: load at frame start (zeros on underrun), shift MSB-first per data bit.
    always_ff @(posedge clk) begin
        if (load_evt) begin
            tx_sh_l <= tx_ready_q ? '0 : hold_l;
            tx_sh_r <= tx_ready_q ? '0 : hold_r;
        end else if (fall_evt && fall_bit) begin
            if (fall_right) begin
                tx_sh_r <= {tx_sh_r[DATA_W-2:0], 1'b0};
            end else begin
                tx_sh_l <= {tx_sh_l[DATA_W-2:0], 1'b0};
            end
        end
    end

    // RX shifters: sample adcdat on bclk rising edges inside the data window.
    always_ff @(posedge clk) begin
        if (rise_evt && rise_bit) begin
            if (rise_right) begin
                rx_sh_r <= {rx_sh_r[DATA_W-2:0], i2s.adcdat};
            end else begin
                rx_sh_l <= {rx_sh_l[DATA_W-2:0], i2s.adcdat};
            end
        end
    end

    // RX output stage: publish both channels one clk after the right LSB is captured.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_vld_p0  <= 1'b0;
            rx_vld_p1  <= 1'b0;
            rx_left_q  <= '0;
            rx_right_q <= '0;
        end else begin
            // p0: right-channel LSB captured this edge
            rx_vld_p0 <= rise_evt && rx_last;
            // p1: sample pair published
            rx_vld_p1 <= rx_vld_p0;
            if (rx_vld_p0) begin
                rx_left_q  <= rx_sh_l;
                rx_right_q <= rx_sh_r;
            end
        end
    end

    assign i2s.bclk        = bclk_q;
    assign i2s.lrclk       = lrclk_q;
    assign i2s.dacdat      = dacdat_q;
    assign i2s.tx_ready    = tx_ready_q;
    assign i2s.tx_underrun = underrun_q;
    assign i2s.rx_left     = rx_left_q;
    assign i2s.rx_right    = rx_right_q;
    assign i2s.rx_valid    = rx_vld_p1;
endmodule
